// File: rtl/ram_bist.sv
// ram_bist: march-test BIST master (write P, read P / write ~P, read ~P) for a single-port RAM
module ram_bist #(
  parameter int DEPTH = 16,
  parameter int RD_LAT = 1,
  parameter logic [31:0] PATTERN = 32'hAAAA_AAAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] fail_addr_o,
  output logic [31:0] fail_data_o
);
  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;
  localparam logic [15:0] LAST = 16'(DEPTH - 1);
  localparam logic [1:0] LAT = 2'(RD_LAT);
  state_t st_q, st_d;
  logic [15:0] idx_q, idx_d, err_q, err_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] fail_addr_q, fail_addr_d, fail_data_q, fail_data_d, addr_q, addr_d, data_q, data_d, exp_data;
  logic pass_q, pass_d, we_q, we_d, busy_q, busy_d, done_q, done_d, cmp, miss;
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    cnt_d = cnt_q;
    err_d = err_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    pass_d = pass_q;
    cmp = (st_q == RD0 || st_q == RD1) && cnt_q == LAT;
    exp_data = st_q == RD1 ? ~PATTERN : PATTERN;
    miss = cmp && (data_i !== exp_data);
    if (miss) begin
      err_d = err_q == 16'hFFFF ? err_q : err_q + 16'd1;
      fail_addr_d = err_q == 16'd0 ? {16'd0, idx_q} : fail_addr_q;
      fail_data_d = err_q == 16'd0 ? data_i : fail_data_q;
    end
    unique case (st_q)
      IDLE: if (start_i) begin
        st_d = WR0;
        idx_d = 16'd0;
        cnt_d = 2'd0;
        err_d = 16'd0;
        fail_addr_d = 32'd0;
        fail_data_d = 32'd0;
        pass_d = 1'b0;
      end
      WR0: begin
        st_d = idx_q == LAST ? RD0 : WR0;
        idx_d = idx_q == LAST ? 16'd0 : idx_q + 16'd1;
      end
      RD0: begin
        st_d = cmp ? WR1 : RD0;
        cnt_d = cmp ? 2'd0 : cnt_q + 2'd1;
      end
      WR1: begin
        st_d = idx_q == LAST ? RD1 : RD0;
        idx_d = idx_q == LAST ? idx_q : idx_q + 16'd1;
      end
      RD1: begin
        st_d = cmp && idx_q == 16'd0 ? DONE : RD1;
        idx_d = cmp && idx_q != 16'd0 ? idx_q - 16'd1 : idx_q;
        cnt_d = cmp ? 2'd0 : cnt_q + 2'd1;
      end
      DONE: st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (st_d == DONE) pass_d = err_d == 16'd0;
    we_d = st_d == WR0 || st_d == WR1;
    addr_d = st_d == IDLE ? 32'd0 : {16'd0, idx_d};
    data_d = st_d == WR0 ? PATTERN : st_d == WR1 ? ~PATTERN : 32'd0;
    busy_d = st_d != IDLE;
    done_d = st_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      idx_q <= 16'd0;
      cnt_q <= 2'd0;
      err_q <= 16'd0;
      fail_addr_q <= 32'd0;
      fail_data_q <= 32'd0;
      pass_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= 32'd0;
      data_q <= 32'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      pass_q <= pass_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign we_o = we_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;
  assign err_cnt_o = err_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed bench for ram_bist against a faultable 1-cycle-read RAM model
module tb_ram_bist;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic we_o, busy_o, done_o, pass_o;
  logic [31:0] addr_o, data_o, data_i, fail_addr_o, fail_data_o;
  logic [15:0] err_cnt_o;
  logic [31:0] mem [16];
  logic [31:0] rdata;
  logic [3:0] ea;
  int mode = 0;
  int wr_cnt = 0;
  int total = 0;
  int passes = 0;
  int nb, nd;
  always #5 clk = ~clk;
  ram_bist dut (
    .clk(clk), .rst(rst), .start_i(start_i), .we_o(we_o), .addr_o(addr_o),
    .data_o(data_o), .data_i(data_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .err_cnt_o(err_cnt_o), .fail_addr_o(fail_addr_o),
    .fail_data_o(fail_data_o)
  );
  assign ea = mode == 2 ? addr_o[3:0] & 4'h7 : addr_o[3:0];
  assign data_i = rdata;
  always @(posedge clk) begin
    if (we_o) begin
      mem[ea] <= (mode == 1 && ea == 4'd5) ? {data_o[31:1], 1'b0} : data_o;
      wr_cnt <= wr_cnt + 1;
    end
    rdata <= mem[ea];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic run(input int sa, input int sb, input int ra, output int b, output int d);
    b = 0;
    d = 0;
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
    chk("first_busy", {31'd0, busy_o}, 32'd1);
    chk("first_we", {31'd0, we_o}, 32'd1);
    chk("first_addr", addr_o, 32'd0);
    for (int c = 0; c < 300 && busy_o; c++) begin
      b++;
      if (done_o) d++;
      start_i = (c == sa || c == sb);
      rst = (c == ra);
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      start_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("rst_ctl", {28'd0, we_o, busy_o, done_o, pass_o}, 32'd0);
      chk("rst_err", {16'd0, err_cnt_o}, 32'd0);
      chk("rst_bus", addr_o | data_o | fail_addr_o | fail_data_o, 32'd0);
    end
    start_i = 1'b0;
    rst = 1'b0;
    chk("rst_no_writes", wr_cnt, 32'd0);
    run(-1, -1, -1, nb, nd);
    chk("good_busy", nb, 32'd97);
    chk("good_done", nd, 32'd1);
    chk("good_pass", {31'd0, pass_o}, 32'd1);
    chk("good_err", {16'd0, err_cnt_o}, 32'd0);
    for (int i = 0; i < 16; i++) chk("good_mem", mem[i], 32'h5555_5555);
    mode = 1;
    run(-1, -1, -1, nb, nd);
    chk("sa0_pass", {31'd0, pass_o}, 32'd0);
    chk("sa0_err", {16'd0, err_cnt_o}, 32'd1);
    chk("sa0_faddr", fail_addr_o, 32'd5);
    chk("sa0_fdata", fail_data_o, 32'h5555_5554);
    mode = 2;
    run(-1, -1, -1, nb, nd);
    chk("alias_pass", {31'd0, pass_o}, 32'd0);
    chk("alias_err", {16'd0, err_cnt_o}, 32'd8);
    chk("alias_faddr", fail_addr_o, 32'd8);
    chk("alias_fdata", fail_data_o, 32'h5555_5555);
    mode = 0;
    run(10, 96, -1, nb, nd);
    chk("ign_busy", nb, 32'd97);
    chk("ign_done", nd, 32'd1);
    chk("ign_pass", {31'd0, pass_o}, 32'd1);
    @(negedge clk);
    chk("ign_idle", {31'd0, busy_o}, 32'd0);
    run(-1, -1, 40, nb, nd);
    rst = 1'b0;
    chk("abort_busy", nb, 32'd41);
    chk("abort_done", nd, 32'd0);
    chk("abort_ctl", {29'd0, we_o, busy_o, pass_o}, 32'd0);
    run(-1, -1, -1, nb, nd);
    chk("rerun_busy", nb, 32'd97);
    chk("rerun_done", nd, 32'd1);
    chk("rerun_pass", {31'd0, pass_o}, 32'd1);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/ram_bist.md
# ram_bist

Synthesizable built-in self-test master for the single-port `ram` block. It drives the RAM's write/address/data inputs and checks its read data, replacing a hand-written testbench sequence with an on-chip march test (write P, read P / write ~P, read ~P). It sits between the system controller, which pulses `start_i` and reads the result, and the `ram` instance, which it owns while `busy_o` is high.

## Interface
Parameters:
- `DEPTH`, 16: number of words tested, at addresses 0..DEPTH-1. Must be 1..65536.
- `RD_LAT`, 1: RAM read latency in cycles, allowed 0..3. `data_i` is valid RD_LAT cycles after `addr_o` is presented with `we_o`=0.
- `PATTERN`, 32'hAAAA_AAAA: background pattern P. Its complement ~P is also used.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `start_i`  in  1: one-cycle start request. Sampled only in IDLE.
- `we_o`  out  1: RAM write enable, connects to `ram.we_i`.
- `addr_o`  out  32: RAM word address (zero-extended index), connects to `ram.addr_i`.
- `data_o`  out  32: RAM write data, connects to `ram.data_i`.
- `data_i`  in  32: RAM read data, from `ram.data_o`.
- `busy_o`  out  1: test in progress (every state except IDLE).
- `done_o`  out  1: one-cycle pulse at end of test.
- `pass_o`  out  1: 1 when the last completed run had zero mismatches.
- `err_cnt_o`  out  16: mismatch count, saturating at 16'hFFFF.
- `fail_addr_o`  out  32: address of the first mismatch in the run.
- `fail_data_o`  out  32: `data_i` at the first mismatch.

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DONE.
- IDLE: `we_o`=0 and bus outputs held at 0. When `start_i`=1, clear `err_cnt_o`, `fail_addr_o`, `fail_data_o` and `pass_o`, set index=0, and go to WR0.
- WR0 (ascending 0..DEPTH-1): `we_o`=1, `data_o`=P, `addr_o`=index. Takes one cycle per address. After DEPTH-1, set index=0 and go to RD0.
- RD0 (ascending): `we_o`=0, `addr_o`=index for RD_LAT+1 cycles (wait counter). On the last cycle, compare `data_i` against P. Then go to WR1.
- WR1: `we_o`=1, `data_o`=~P at the same index, for one cycle. Then increment the index and return to RD0. After DEPTH-1, set index=DEPTH-1 and go to RD1.
- RD1 (descending DEPTH-1..0): read as in RD0, compare against ~P. After index 0, go to DONE.
- DONE: lasts one cycle. `done_o`=1, `pass_o` is set to (err_cnt==0), `busy_o` stays 1. Then go to IDLE.
- Mismatch handling: increment `err_cnt_o`, saturating. If this is the first mismatch of the run, capture `addr_o` into `fail_addr_o` and `data_i` into `fail_data_o`. Later mismatches do not overwrite them.
- Compare is 32-bit exact equality. X or Z on `data_i` is treated as a mismatch in simulation.
- `start_i` is ignored in every state except IDLE, including DONE.
- Results persist in IDLE until the next accepted start.

## Timing
- Reset values: all outputs 0 (`we_o`, `addr_o`, `data_o`, `busy_o`, `done_o`, `pass_o`, `err_cnt_o`, `fail_*`). State is IDLE.
- `rst` mid-test: at the next edge the block is in IDLE with all outputs 0, so `we_o` drops within one cycle. No `done_o` pulse is issued for an aborted run.
- `start_i` high at edge N (in IDLE): at edge N+1, `busy_o`=1, `we_o`=1, `addr_o`=0.
- Cycles in busy: DEPTH + DEPTH·(RD_LAT+2) + DEPTH·(RD_LAT+1) + 1 (DONE).
  - DEPTH=16, RD_LAT=1 gives 16+48+32+1 = 97 cycles.
- `done_o` is high for exactly one cycle. `busy_o` falls on the following cycle.
- `pass_o` is valid from the `done_o` cycle onward.
- All outputs are registered. `data_i` is sampled only on the compare cycle.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with random `start_i` -> all outputs 0, no RAM writes.
- Good RAM (behavioral 1-cycle-read model), DEPTH=16, RD_LAT=1: pulse start -> `busy_o` high 97 cycles, single `done_o` pulse, `pass_o`=1, `err_cnt_o`=0; model memory holds 32'h5555_5555 at every address.
- Stuck-at-0 on bit 0 of address 5 -> `pass_o`=0, `err_cnt_o`=1, `fail_addr_o`=5, `fail_data_o`=32'h5555_5554 (detected in RD1).
- Address alias (model ignores addr bit 3) -> `err_cnt_o`=8, `fail_addr_o`=8, `fail_data_o`=32'h5555_5555, `pass_o`=0.
- Pulse `start_i` at busy cycles 10 and 96 (the DONE cycle) -> both ignored, total busy still 97 cycles, one `done_o` pulse.
- Assert `rst` at busy cycle 40 -> next cycle `we_o`=0, `busy_o`=0, no `done_o`. A new start then completes a full run with `pass_o`=1.
